// File: rtl/peripheral_pio_pkg.sv
// rtl/peripheral_pio_pkg.sv - register map and edge-select encodings for the GPIO PIO
package peripheral_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// rtl/pio_sync_edge.sv - pin synchroniser, previous-value register, settling counter and edge detect
module pio_sync_edge
    import peripheral_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int SETTLE = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [2:0]                        settle_q, settle_d;
    logic                              settled;
    logic [WIDTH-1:0]                  rise, fall;

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign settled = (settle_q == 3'(SETTLE));

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d   = in_sync;
        settle_d = settled ? settle_q : settle_q + 3'd1;
        rise     = in_sync & ~prev_q;
        fall     = ~in_sync & prev_q;
        case (EDGE_TYPE)
            EDGE_FALL: edge_pulse = fall;
            EDGE_ANY:  edge_pulse = rise | fall;
            default:   edge_pulse = rise;
        endcase
        // Hold off capture until the chain has flushed the reset zeros.
        if (!settled) begin
            edge_pulse = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            settle_q <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/peripheral_system_gpio_pio.sv
// rtl/peripheral_system_gpio_pio.sv - Avalon-MM GPIO port with direction, set/clear, edge capture and IRQ
module peripheral_system_gpio_pio
    import peripheral_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] in_sync, edge_pulse, wd, clr;
    logic [31:0]      rd_word;
    logic             wr;
    logic             unused_wd;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr        = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_out_d = wd;
                ADDR_DIR:      dir_d      = wd;
                ADDR_IRQ_MASK: mask_d     = wd;
                ADDR_EDGE_CAP: clr        = wd;
                ADDR_OUTSET:   data_out_d = data_out_q | wd;
                ADDR_OUTCLR:   data_out_d = data_out_q & ~wd;
                default:       ;
            endcase
        end
        // A fresh edge beats a same-cycle clear so no event is lost.
        edge_cap_d = (edge_cap_q & ~clr) | edge_pulse;
        irq_d      = |(edge_cap_q & mask_q);
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:     rd_word[WIDTH-1:0] = (dir_q & data_out_q) | (~dir_q & in_sync);
            ADDR_DIR:      rd_word[WIDTH-1:0] = dir_q;
            ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap_q;
            default:       ;
        endcase
        readdata_d = chipselect ? rd_word : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= OUT_RESET;
            dir_q      <= DIR_RESET;
            mask_q     <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign out_port = data_out_q;
    assign oe       = dir_q;
    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_peripheral_system_gpio_pio.sv
// tb/tb_peripheral_system_gpio_pio.sv - self-checking bench for the GPIO PIO against a pin-history model
module tb_peripheral_system_gpio_pio;
    import peripheral_pio_pkg::*;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    always #5 clk = ~clk;

    peripheral_system_gpio_pio #(
        .WIDTH       (8),
        .OUT_RESET   (8'h00),
        .DIR_RESET   (8'hFF),
        .EDGE_TYPE   (EDGE_RISE),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    int checks = 0;
    int errors = 0;

    // Model: pin value present at each clock edge since reset release
    logic [7:0]  hist [0:2047];
    int          k;
    logic [7:0]  m_out, m_dir, m_mask, m_cap;
    logic        m_irq;
    logic [31:0] m_rd;

    function automatic logic [7:0] sync_at(input int j);
        return (j - S >= 1) ? hist[j-S] : 8'h00;
    endfunction

    task automatic model_reset();
        m_out = 8'h00; m_dir = 8'hFF; m_mask = 8'h00; m_cap = 8'h00;
        m_irq = 1'b0;  m_rd = 32'h0;  k = 0;
    endtask

    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] wd, input logic [7:0] pin);
        logic [7:0] is, pv, ev, clr, w8;
        logic       wr, n_irq;
        chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = pin;
        k = k + 1;
        hist[k] = pin;
        is = sync_at(k);
        pv = sync_at(k - 1);
        ev = (k >= S + 2) ? (is & ~pv) : 8'h00;
        wr = cs & ~wn;
        w8 = wd[7:0];
        if (cs) begin
            case (a)
                ADDR_DATA:     m_rd = {24'h0, (m_dir & m_out) | (~m_dir & is)};
                ADDR_DIR:      m_rd = {24'h0, m_dir};
                ADDR_IRQ_MASK: m_rd = {24'h0, m_mask};
                ADDR_EDGE_CAP: m_rd = {24'h0, m_cap};
                default:       m_rd = 32'h0;
            endcase
        end
        n_irq = |(m_cap & m_mask);
        clr = (wr && a == ADDR_EDGE_CAP) ? w8 : 8'h00;
        if (wr) begin
            case (a)
                ADDR_DATA:     m_out = w8;
                ADDR_DIR:      m_dir = w8;
                ADDR_IRQ_MASK: m_mask = w8;
                ADDR_OUTSET:   m_out = m_out | w8;
                ADDR_OUTCLR:   m_out = m_out & ~w8;
                default:       ;
            endcase
        end
        m_cap = (m_cap & ~clr) | ev;
        m_irq = n_irq;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        in_port = 8'h00;
        apply_reset();
        checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out_port got %h exp 00", out_port); end
        checks++; if (oe !== 8'hFF) begin errors++; $display("FAIL reset_oe got %h exp ff", oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", readdata); end
        cycle(1, 1, ADDR_DATA, 32'h0, 8'h00);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_data_read got %h exp 0", readdata); end
    endtask

    task automatic test_set_clear();
        cycle(1, 0, ADDR_DATA, 32'h0000_00A5, 8'h00);
        checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL data_write got %h exp a5", out_port); end
        cycle(1, 0, ADDR_OUTSET, 32'h0000_000A, 8'h00);
        checks++; if (out_port !== 8'hAF) begin errors++; $display("FAIL outset got %h exp af", out_port); end
        cycle(1, 0, ADDR_OUTCLR, 32'h0000_0081, 8'h00);
        checks++; if (out_port !== 8'h2E) begin errors++; $display("FAIL outclr got %h exp 2e", out_port); end
        cycle(1, 1, ADDR_OUTSET, 32'h0, 8'h00);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL outset_read got %h exp 0", readdata); end
    endtask

    task automatic test_read_mux();
        cycle(1, 0, ADDR_DIR, 32'hFFFF_FF0F, 8'h00);
        cycle(1, 0, ADDR_DATA, 32'h0000_0003, 8'hC0);
        for (int i = 0; i < 3; i++) cycle(0, 1, ADDR_DATA, 32'h0, 8'hC0);
        cycle(1, 1, ADDR_DATA, 32'h0, 8'hC0);
        checks++; if (readdata !== 32'h0000_00C3) begin errors++; $display("FAIL data_mux_read got %h exp c3", readdata); end
        checks++; if (readdata[31:8] !== 24'h0) begin errors++; $display("FAIL read_upper_zero got %h exp 0", readdata[31:8]); end
        checks++; if (oe !== 8'h0F) begin errors++; $display("FAIL dir_write got %h exp 0f", oe); end
    endtask

    task automatic test_edge_irq();
        cycle(1, 0, ADDR_EDGE_CAP, 32'hFF, 8'hC0);
        cycle(1, 0, ADDR_IRQ_MASK, 32'h01, 8'hC0);
        cycle(0, 1, ADDR_DATA, 32'h0, 8'hC0);
        cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hC1);
        cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hC1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_n1 got %b exp 0", irq); end
        cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hC1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_n2 got %b exp 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL cap_before_n2 got %h exp 0", readdata); end
        cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hC1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_n3 got %b exp 1", irq); end
        checks++; if (readdata !== 32'h01) begin errors++; $display("FAIL cap_after_n2 got %h exp 01", readdata); end
        cycle(1, 0, ADDR_EDGE_CAP, 32'h01, 8'hC1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_w1c got %b exp 1", irq); end
        cycle(0, 1, ADDR_DATA, 32'h0, 8'hC1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c got %b exp 0", irq); end
    endtask

    task automatic test_w1c_race();
        cycle(0, 1, ADDR_DATA, 32'h0, 8'hC3);
        cycle(0, 1, ADDR_DATA, 32'h0, 8'hC3);
        cycle(1, 0, ADDR_EDGE_CAP, 32'h02, 8'hC3);
        cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hC3);
        checks++; if (readdata !== 32'h02) begin errors++; $display("FAIL set_beats_clear got %h exp 02", readdata); end
        cycle(1, 0, ADDR_EDGE_CAP, 32'h02, 8'hC3);
        cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hC3);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", readdata); end
    endtask

    task automatic test_random();
        logic [7:0] pin;
        pin = 8'hC3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) pin = 8'($urandom);
            cycle(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 3'($urandom), $urandom, pin);
            checks++; if (out_port !== m_out) begin errors++; $display("FAIL rand_out_port cyc %0d got %h exp %h", i, out_port, m_out); end
            checks++; if (oe !== m_dir) begin errors++; $display("FAIL rand_oe cyc %0d got %h exp %h", i, oe, m_dir); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc %0d got %b exp %b", i, irq, m_irq); end
            checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata cyc %0d got %h exp %h", i, readdata, m_rd); end
        end
    endtask

    task automatic test_reset_midway();
        cycle(1, 0, ADDR_DIR, 32'h0F, 8'h00);
        cycle(1, 0, ADDR_DATA, 32'h55, 8'h00);
        cycle(1, 0, ADDR_IRQ_MASK, 32'hFF, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 1, ADDR_DATA, 32'h0, 8'hFF);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset got %b exp 1", irq); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL mid_reset_out got %h exp 00", out_port); end
        checks++; if (oe !== 8'hFF) begin errors++; $display("FAIL mid_reset_oe got %h exp ff", oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b exp 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_readdata got %h exp 0", readdata); end
        chipselect = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, ADDR_EDGE_CAP, 32'h0, 8'hFF);
            checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL settle_cap cyc %0d got %h exp 0", i, readdata); end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL settle_irq cyc %0d got %b exp 0", i, irq); end
        end
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        writedata = 32'h0; in_port = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_set_clear();
        test_read_mux();
        test_edge_irq();
        test_w1c_race();
        test_random();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
